// File: rtl/step_sequencer.sv
// step_sequencer: single-axis stepper move controller.
//
// Accepts one counted move (step count, direction, step period) over a
// valid/ready handshake. It sets the direction, waits out the direction
// setup time, then emits the step pulse train. It reports busy, remaining
// steps and completion, and supports an early abort.
//
// Optional build macro: STEP_SEQ_POSITION_EN adds a signed 32-bit step
// position counter (position) with an idle-only synchronous clear
// (pos_clear).
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset       asynchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   controller can accept a command (high only in IDLE)
//   cmd_steps   number of step pulses to issue
//   cmd_dir     direction for the move
//   cmd_period  rising-edge-to-rising-edge step period, in cycles
//   abort       early stop request (level, sampled each cycle)
//   step_out    step pulse to the motor driver
//   dir_out     direction to the motor driver
//   busy        high in any state except IDLE
//   done        one-cycle pulse at move end
//   aborted     valid with done: move ended by abort
//   remaining   steps not yet started
//   pos_clear   (STEP_SEQ_POSITION_EN) clear position, honoured in IDLE
//   position    (STEP_SEQ_POSITION_EN) signed step position

module step_sequencer #(
  parameter int unsigned      STEP_W     = 16,
  parameter int unsigned      PER_W      = 28,
  parameter logic [PER_W-1:0] PULSE_HIGH = PER_W'(1001),
  parameter logic [PER_W-1:0] DIR_SETUP  = PER_W'(50)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic [PER_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              step_out,
  output logic              dir_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] remaining
`ifdef STEP_SEQ_POSITION_EN
  ,
  input  logic              pos_clear,
  output logic signed [31:0] position
`endif
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_PULSE_HI = 3'd2;
  localparam logic [2:0] ST_PULSE_LO = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Shortest legal period leaves at least one low cycle per step.
  localparam logic [PER_W-1:0] MIN_PERIOD = PULSE_HIGH + PER_W'(1);
  // Phase counters count down to zero, so each phase loads length-1.
  localparam logic [PER_W-1:0] HI_LOAD    = PULSE_HIGH - PER_W'(1);
  localparam logic [PER_W-1:0] SETUP_LOAD = DIR_SETUP - PER_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] cnt_nxt;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] period_clamped;
  logic             abort_lat;
  logic             accept;
  logic             end_abort;
  logic             enter_hi;

  // Period latched at accept, never shorter than MIN_PERIOD.
  assign period_clamped = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, phase counter and handshake decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    end_abort = 1'b0;
    enter_hi  = 1'b0;
    cnt_nxt   = cnt;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_steps == '0) begin
            state_nxt = ST_DONE;
          end else if (DIR_SETUP == '0) begin
            state_nxt = ST_PULSE_HI;
          end else begin
            state_nxt = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (abort) begin
          state_nxt = ST_DONE;
          end_abort = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = ST_PULSE_HI;
        end
      end
      ST_PULSE_HI: begin
        // The high phase always runs to full width; abort takes effect after.
        if (cnt == '0) begin
          if (abort || abort_lat) begin
            state_nxt = ST_DONE;
            end_abort = 1'b1;
          end else begin
            state_nxt = ST_PULSE_LO;
          end
        end
      end
      ST_PULSE_LO: begin
        if (abort) begin
          state_nxt = ST_DONE;
          end_abort = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = (remaining != '0) ? ST_PULSE_HI : ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    enter_hi = (state_nxt == ST_PULSE_HI) && (state != ST_PULSE_HI);

    // Load the phase length on every state change, otherwise count down.
    if (state_nxt != state) begin
      case (state_nxt)
        ST_SETUP:    cnt_nxt = SETUP_LOAD;
        ST_PULSE_HI: cnt_nxt = HI_LOAD;
        ST_PULSE_LO: cnt_nxt = period - MIN_PERIOD;
        default:     cnt_nxt = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nxt = cnt - PER_W'(1);
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_ready <= 1'b1;
      step_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == ST_IDLE);
      step_out  <= (state_nxt == ST_PULSE_HI);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      aborted   <= (state_nxt == ST_DONE) && end_abort;
    end
  end

  // Move parameters, step count and the mid-pulse abort latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dir_out   <= 1'b0;
      period    <= '0;
      remaining <= '0;
      abort_lat <= 1'b0;
    end else begin
      if (accept) begin
        dir_out <= cmd_dir;
        period  <= period_clamped;
      end

      // With no setup delay the first pulse starts on the accept edge.
      if (accept) begin
        remaining <= enter_hi ? (cmd_steps - STEP_W'(1)) : cmd_steps;
      end else if (enter_hi) begin
        remaining <= remaining - STEP_W'(1);
      end

      // Remember an abort seen anywhere in the high phase.
      if (state == ST_PULSE_HI) begin
        abort_lat <= abort_lat | abort;
      end else begin
        abort_lat <= 1'b0;
      end
    end
  end

`ifdef STEP_SEQ_POSITION_EN
  logic              pos_dir;
  logic signed [31:0] pos_base;

  // On the accept edge dir_out still holds the previous move's direction.
  assign pos_dir  = accept ? cmd_dir : dir_out;
  assign pos_base = ((state == ST_IDLE) && pos_clear) ? 32'sd0 : position;

  // Position tracks every started pulse, wrapping in two's complement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      position <= 32'sd0;
    end else if (enter_hi) begin
      position <= pos_dir ? (pos_base + 32'sd1) : (pos_base - 32'sd1);
    end else if ((state == ST_IDLE) && pos_clear) begin
      position <= 32'sd0;
    end
  end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed bench for step_sequencer with PULSE_HIGH=2,
// DIR_SETUP=3. Table-driven moves plus hand-written corner sequences.

module tb_step_sequencer;

  localparam int unsigned STEP_W = 16;
  localparam int unsigned PER_W  = 28;
  localparam int          PH     = 2;
  localparam int          LIMIT  = 300;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic [PER_W-1:0]  cmd_period;
  logic              abort;
  logic              step_out;
  logic              dir_out;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] remaining;
`ifdef STEP_SEQ_POSITION_EN
  logic              pos_clear;
  logic signed [31:0] position;
`endif

  int checks = 0;
  int errors = 0;

  step_sequencer #(
    .STEP_W    (STEP_W),
    .PER_W     (PER_W),
    .PULSE_HIGH(28'd2),
    .DIR_SETUP (28'd3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_period(cmd_period),
    .abort     (abort),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .remaining (remaining)
`ifdef STEP_SEQ_POSITION_EN
    ,
    .pos_clear (pos_clear),
    .position  (position)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One move record: command, abort cycle (-1 none) and expected outcome.
  // Cycle indices count edges after the accept edge (accept edge = 0).
  typedef struct {
    logic [STEP_W-1:0] steps;
    logic              dir;
    logic [PER_W-1:0]  period;
    int                abort_at;
    int                exp_first;
    int                exp_space;
    int                exp_pulses;
    int                exp_done;
    logic              exp_aborted;
    logic [STEP_W-1:0] exp_rem;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one move, watch it cycle by cycle and compare its outcome.
  task automatic run_vec(input vec_t v);
    int   first;
    int   pulses;
    int   last_rise;
    int   width;
    int   done_idx;
    int   done_ab;
    int   done_rem;
    logic prev;
    logic spacing_bad;
    logic width_bad;
    logic rem_bad;
    logic busy_bad;
    logic dir_bad;
    first = -1; pulses = 0; last_rise = 0; width = 0; done_idx = -1;
    done_ab = 0; done_rem = 0; prev = 1'b0;
    spacing_bad = 1'b0; width_bad = 1'b0; rem_bad = 1'b0;
    busy_bad = 1'b0; dir_bad = 1'b0;

    @(negedge clock);
    cmd_steps  = v.steps;
    cmd_dir    = v.dir;
    cmd_period = v.period;
    cmd_valid  = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;

    for (int k = 0; k <= LIMIT; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      if (step_out && !prev) begin
        if (pulses == 0) first = k;
        else if (k - last_rise != v.exp_space) spacing_bad = 1'b1;
        last_rise = k;
        pulses++;
        if (int'(remaining) != int'(v.steps) - pulses) rem_bad = 1'b1;
        width = 1;
      end else if (step_out) begin
        width++;
      end else if (prev && width != PH) begin
        width_bad = 1'b1;
      end
      prev = step_out;
      if (!busy) busy_bad = 1'b1;
      if (dir_out != v.dir) dir_bad = 1'b1;
      if (done) begin
        done_idx = k;
        done_ab  = int'(aborted);
        done_rem = int'(remaining);
        break;
      end
      abort = (v.abort_at == k + 1);
    end
    abort = 1'b0;

    chk("done_cycle", done_idx, v.exp_done);
    chk("first_rise", first, v.exp_first);
    chk("pulse_count", pulses, v.exp_pulses);
    chk("aborted", done_ab, int'(v.exp_aborted));
    chk("rem_at_done", done_rem, int'(v.exp_rem));
    chk("step_spacing_bad", int'(spacing_bad), 0);
    chk("pulse_width_bad", int'(width_bad), 0);
    chk("rem_at_rise_bad", int'(rem_bad), 0);
    chk("busy_drop_bad", int'(busy_bad), 0);
    chk("dir_hold_bad", int'(dir_bad), 0);

    @(posedge clock);
    #1;
    chk("ready_after_done", int'(cmd_ready), 1);
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int   d;
    logic rdy_bad;
    logic dir_bad;

    vecs[0] = '{16'd3, 1'b1, 28'd5,  -1,  3, 5, 3, 18, 1'b0, 16'd0};
    vecs[1] = '{16'd0, 1'b1, 28'd7,  -1, -1, 0, 0,  0, 1'b0, 16'd0};
    vecs[2] = '{16'd5, 1'b0, 28'd1,  -1,  3, 3, 5, 18, 1'b0, 16'd0};
    vecs[3] = '{16'd2, 1'b1, 28'd4,  -1,  3, 4, 2, 11, 1'b0, 16'd0};
    vecs[4] = '{16'd1, 1'b0, 28'd10, -1,  3, 0, 1, 13, 1'b0, 16'd0};
    vecs[5] = '{16'd5, 1'b1, 28'd5,   9,  3, 5, 2, 10, 1'b1, 16'd3};
    vecs[6] = '{16'd4, 1'b0, 28'd5,   6,  3, 5, 1,  6, 1'b1, 16'd3};
    vecs[7] = '{16'd2, 1'b1, 28'd5,   1, -1, 0, 0,  1, 1'b1, 16'd2};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_dir    = 1'b0;
    cmd_period = '0;
    abort      = 1'b0;
`ifdef STEP_SEQ_POSITION_EN
    pos_clear  = 1'b0;
`endif

    // Reset state.
    #12;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_step_out", int'(step_out), 0);
    chk("rst_dir_out", int'(dir_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_remaining", int'(remaining), 0);
    #11;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Command held valid during a move: no early accept, dir_out unchanged.
    @(negedge clock);
    cmd_steps  = 16'd2;
    cmd_dir    = 1'b1;
    cmd_period = 28'd3;
    cmd_valid  = 1'b1;
    @(posedge clock);
    #1;
    chk("held_first_busy", int'(busy), 1);
    cmd_steps = 16'd1;
    cmd_dir   = 1'b0;
    d = -1;
    rdy_bad = 1'b0;
    dir_bad = 1'b0;
    for (int k = 0; k <= LIMIT; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      if (cmd_ready) rdy_bad = 1'b1;
      if (dir_out != 1'b1) dir_bad = 1'b1;
      if (done) begin
        d = k;
        break;
      end
    end
    chk("held_done_cycle", d, 9);
    chk("held_ready_low_bad", int'(rdy_bad), 0);
    chk("held_dir_change_bad", int'(dir_bad), 0);
    @(posedge clock);
    #1;
    chk("held_idle_ready", int'(cmd_ready), 1);
    chk("held_idle_busy", int'(busy), 0);
    chk("held_idle_dir", int'(dir_out), 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    chk("held_second_busy", int'(busy), 1);
    chk("held_second_dir", int'(dir_out), 0);
    chk("held_second_rem", int'(remaining), 1);
    d = -1;
    for (int k = 0; k <= LIMIT; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        d = k;
        break;
      end
    end
    chk("held_second_done_found", int'(d >= 0), 1);
    @(posedge clock);
    #1;

`ifdef STEP_SEQ_POSITION_EN
    // Position: clear, +4 steps, then 6 steps the other way.
    @(negedge clock);
    pos_clear = 1'b1;
    @(negedge clock);
    pos_clear = 1'b0;
    chk("pos_cleared", int'(position), 0);
    run_vec('{16'd4, 1'b1, 28'd3, -1, 3, 3, 4, 15, 1'b0, 16'd0});
    chk("pos_after_fwd", int'(position), 4);
    run_vec('{16'd6, 1'b0, 28'd3, -1, 3, 3, 6, 21, 1'b0, 16'd0});
    chk("pos_after_back", int'(position), -2);
`endif

    // Asynchronous reset in the middle of a high phase.
    @(negedge clock);
    cmd_steps  = 16'd3;
    cmd_dir    = 1'b1;
    cmd_period = 28'd5;
    cmd_valid  = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    d = -1;
    for (int k = 0; k <= 50; k++) begin
      if (step_out) begin
        d = k;
        break;
      end
      @(posedge clock);
      #1;
    end
    chk("mid_reset_pulse_seen", int'(d >= 0), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_step_out", int'(step_out), 0);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_remaining", int'(remaining), 0);
    chk("mid_reset_cmd_ready", int'(cmd_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_reset_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
